// File: rtl/des_round_sequencer_if.sv
// Block/key source, f-unit and result consumer bundle for the iterative DES round sequencer.
// Bit 0 of every vector is the FIPS MSB, so the vectors are declared ascending [0:N-1].
interface des_round_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_decrypt;
  logic [0:63] in_data;
  logic [0:55] in_key_cd;
  logic [0:31] f_r;
  logic [0:55] f_cd;
  logic [0:31] f_out;
  logic        out_valid;
  logic        out_ready;
  logic [0:63] out_data;
  logic        busy;

  // Sequencer side.
  modport slave (
    input  in_valid, in_decrypt, in_data, in_key_cd, f_out, out_ready,
    output in_ready, f_r, f_cd, out_valid, out_data, busy
  );

  // Environment side: block source, f-unit and consumer.
  modport master (
    output in_valid, in_decrypt, in_data, in_key_cd, f_out, out_ready,
    input  in_ready, f_r, f_cd, out_valid, out_data, busy
  );
endinterface

// File: rtl/des_round_sequencer.sv
// Iterative DES controller: IP on accept, one Feistel round per clock through an external f-unit,
// C/D key schedule for encrypt and decrypt, then swap and FP into a held output register.
module des_round_sequencer #(
  parameter int NUM_ROUNDS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  des_round_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_DONE} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [0:31] r_l;
  logic [0:31] r_r;
  logic [0:27] r_c;
  logic [0:27] r_d;
  logic        r_mode;
  logic [4:0]  r_round_cnt;
  logic [0:63] r_out_data;

  logic        w_last;
  logic [0:31] w_r_new;
  logic [0:27] w_c_first;
  logic [0:27] w_d_first;
  logic [0:27] w_c_step;
  logic [0:27] w_d_step;
  logic        w_step_two;

  // 0-based IP source index; IP rows walk even bits then odd bits downward in steps of 8.
  function automatic int ip_src(input int i);
    return (((i / 8) < 4) ? (57 + 2 * (i / 8)) : (48 + 2 * (i / 8))) - 8 * (i % 8);
  endfunction

  function automatic logic [0:63] ip_perm(input logic [0:63] x);
    logic [0:63] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[i] = x[ip_src(i)];
    return y;
  endfunction

  function automatic logic [0:63] fp_perm(input logic [0:63] x);
    logic [0:63] y;
    y = '0;
    for (int i = 0; i < 64; i++) y[ip_src(i)] = x[i];
    return y;
  endfunction

  function automatic logic [0:27] rot28(input logic [0:27] x, input logic left, input logic two);
    if (left) return two ? {x[2:27], x[0:1]} : {x[1:27], x[0]};
    else      return two ? {x[26:27], x[0:25]} : {x[27], x[0:26]};
  endfunction

  // Rounds 1, 2, 9 and 16 shift by one; every other round shifts by two.
  function automatic logic shift_is_two(input logic [4:0] n);
    return !((n == 5'd1) || (n == 5'd2) || (n == 5'd9) || (n == 5'd16));
  endfunction

  assign w_last     = (r_round_cnt == 5'(NUM_ROUNDS));
  assign w_r_new    = r_l ^ bus.f_out;
  // Decrypt walks the encrypt schedule backwards, so round i undoes the shift of encrypt round 18-i.
  assign w_step_two = r_mode ? shift_is_two(5'd17 - r_round_cnt) : shift_is_two(r_round_cnt + 5'd1);
  assign w_c_step   = rot28(r_c, !r_mode, w_step_two);
  assign w_d_step   = rot28(r_d, !r_mode, w_step_two);
  assign w_c_first  = bus.in_decrypt ? bus.in_key_cd[0:27]  : rot28(bus.in_key_cd[0:27], 1'b1, 1'b0);
  assign w_d_first  = bus.in_decrypt ? bus.in_key_cd[28:55] : rot28(bus.in_key_cd[28:55], 1'b1, 1'b0);

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.busy      = (r_state != S_IDLE);
  assign bus.f_r       = r_r;
  assign bus.f_cd      = {r_c, r_d};
  assign bus.out_data  = r_out_data;

  // NOTE: sequential state is updated with <= so every register samples pre-edge values together.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.in_valid)  w_next_state = S_ROUND;
      S_ROUND: if (w_last)        w_next_state = S_DONE;
      S_DONE:  if (bus.out_ready) w_next_state = S_IDLE;
      default:                    w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_l         <= '0;
      r_r         <= '0;
      r_c         <= '0;
      r_d         <= '0;
      r_mode      <= 1'b0;
      r_round_cnt <= '0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            {r_l, r_r}  <= ip_perm(bus.in_data);
            r_mode      <= bus.in_decrypt;
            r_round_cnt <= 5'd1;
            r_c         <= w_c_first;
            r_d         <= w_d_first;
          end
        end
        S_ROUND: begin
          r_l         <= r_r;
          r_r         <= w_r_new;
          r_round_cnt <= r_round_cnt + 5'd1;
          r_c         <= w_c_step;
          r_d         <= w_d_step;
          // Final swap: the output is FP(R16 || L16), where L16 is the outgoing R.
          if (w_last) r_out_data <= fp_perm({w_r_new, r_r});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench for des_round_sequencer with a behavioural f-unit (PC-2, E, S-boxes, P)
// and known-answer DES vectors, including complement-property variants.
module tb_des_round_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  des_round_sequencer_if bus ();

  des_round_sequencer #(.NUM_ROUNDS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam int PC2 [48] = '{14,17,11,24, 1, 5, 3,28,15, 6,21,10,23,19,12, 4,26, 8,16, 7,27,20,13, 2,
                              41,52,31,37,47,55,30,40,51,45,33,48,44,49,39,56,34,53,46,42,50,36,29,32};
  localparam int PP [32]  = '{16, 7,20,21,29,12,28,17, 1,15,23,26, 5,18,31,10,
                               2, 8,24,14,32,27, 3, 9,19,13,30, 6,22,11, 4,25};
  localparam int CUM [16] = '{1,2,4,6,8,10,12,14,15,17,19,21,23,25,27,28};
  localparam int SBOX [8][64] = '{
    '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
      4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
    '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
      0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
    '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
      13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
    '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
      10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
    '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
      4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
    '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
      9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
    '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
      1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
    '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
      7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
  };

  function automatic logic [0:31] des_f(input logic [0:31] r, input logic [0:55] cd);
    logic [0:47] k;
    logic [0:47] x;
    logic [0:31] s;
    logic [0:31] p;
    logic [0:5]  b;
    int          v;
    for (int i = 0; i < 48; i++) k[i] = cd[PC2[i] - 1];
    for (int g = 0; g < 8; g++)
      for (int j = 0; j < 6; j++) x[6*g + j] = r[(4*g + j + 31) % 32] ^ k[6*g + j];
    for (int g = 0; g < 8; g++) begin
      for (int j = 0; j < 6; j++) b[j] = x[6*g + j];
      v = SBOX[g][(2*int'(b[0]) + int'(b[5])) * 16 +
                  8*int'(b[1]) + 4*int'(b[2]) + 2*int'(b[3]) + int'(b[4])];
      for (int j = 0; j < 4; j++) s[4*g + j] = v[3 - j];
    end
    for (int i = 0; i < 32; i++) p[i] = s[PP[i] - 1];
    return p;
  endfunction

  // Round key C/D from the cumulative left-shift count; decrypt round i reuses encrypt round 17-i.
  function automatic logic [0:55] model_cd(input logic [0:55] key, input int round, input logic dec);
    logic [0:55] y;
    int          n;
    n = dec ? CUM[16 - round] : CUM[round - 1];
    for (int j = 0; j < 28; j++) begin
      y[j]      = key[(j + n) % 28];
      y[28 + j] = key[28 + (j + n) % 28];
    end
    return y;
  endfunction

  always_comb bus.f_out = des_f(bus.f_r, bus.f_cd);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge with the DUT idle; returns at the negedge where in_ready is back.
  task automatic run_block(input string tag, input logic [0:63] data, input logic [0:55] key,
                           input logic dec, input logic [0:63] exp, input bit sched,
                           input bit keep_valid, input int stall);
    check({tag, " ready"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid   = 1'b1;
    bus.in_data    = data;
    bus.in_key_cd  = key;
    bus.in_decrypt = dec;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("%s r%0d rdy/ov/busy", tag, k),
            64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b001);
      if (sched) check($sformatf("%s r%0d f_cd", tag, k), 64'(bus.f_cd), 64'(model_cd(key, k, dec)));
      if (k == 1 && !keep_valid) bus.in_valid = 1'b0;
    end
    @(negedge clk);
    check({tag, " done rdy/ov/busy"}, 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b011);
    check({tag, " out_data"}, 64'(bus.out_data), 64'(exp));
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(negedge clk);
        check($sformatf("%s stall%0d out_data", tag, s), 64'(bus.out_data), 64'(exp));
        check($sformatf("%s stall%0d rdy/ov", tag, s), 64'({bus.in_ready, bus.out_valid}), 64'b01);
      end
      bus.out_ready = 1'b1;
    end
    @(negedge clk);
    check({tag, " retire rdy/ov/busy"}, 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
  endtask

  localparam logic [0:55] KEY_FIPS = 56'hF0CCAAF556678F;
  localparam logic [0:55] KEY_COMP = 56'h0F33550AA99870;
  localparam logic [0:55] KEY_ZERO = 56'h0;
  localparam logic [0:55] KEY_ONES = 56'hFFFFFFFFFFFFFF;

  initial begin
    rst            = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_decrypt = 1'b0;
    bus.in_data    = '0;
    bus.in_key_cd  = '0;
    bus.out_ready  = 1'b1;
    repeat (3) @(negedge clk);
    check("reset rdy/ov/busy", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    check("reset out_data", 64'(bus.out_data), 64'd0);
    check("reset f_cd", 64'(bus.f_cd), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_block("fips_enc", 64'h0123456789ABCDEF, KEY_FIPS, 1'b0, 64'h85E813540F0AB405, 1'b1, 1'b0, 0);
    run_block("fips_dec", 64'h85E813540F0AB405, KEY_FIPS, 1'b1, 64'h0123456789ABCDEF, 1'b1, 1'b0, 0);

    // Abort in round 7: the pending state and the previous result must both be cleared.
    bus.in_valid   = 1'b1;
    bus.in_data    = 64'h0123456789ABCDEF;
    bus.in_key_cd  = KEY_FIPS;
    bus.in_decrypt = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid r7 f_cd", 64'(bus.f_cd), 64'(model_cd(KEY_FIPS, 7, 1'b0)));
    rst = 1'b1;
    @(negedge clk);
    check("midrst rdy/ov/busy", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    check("midrst out_data", 64'(bus.out_data), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_block("post_rst_enc", 64'h0123456789ABCDEF, KEY_FIPS, 1'b0, 64'h85E813540F0AB405, 1'b0, 1'b0, 0);

    run_block("zero_enc", 64'h0, KEY_ZERO, 1'b0, 64'h8CA64DE9C1B123A7, 1'b0, 1'b0, 0);
    run_block("ones_stall", 64'hFFFFFFFFFFFFFFFF, KEY_ONES, 1'b0, 64'h7359B2163E4EDC58, 1'b0, 1'b0, 10);

    // in_valid held high across four blocks; each block retires before the next is accepted.
    run_block("b2b0", 64'h0123456789ABCDEF, KEY_FIPS, 1'b0, 64'h85E813540F0AB405, 1'b0, 1'b1, 0);
    run_block("b2b1", 64'h85E813540F0AB405, KEY_FIPS, 1'b1, 64'h0123456789ABCDEF, 1'b0, 1'b1, 0);
    run_block("b2b2", 64'hFEDCBA9876543210, KEY_COMP, 1'b0, 64'h7A17ECABF0F54BFA, 1'b1, 1'b1, 0);
    run_block("b2b3", 64'h8CA64DE9C1B123A7, KEY_ZERO, 1'b1, 64'h0, 1'b0, 1'b1, 0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("final idle rdy/ov/busy", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
